// File: rtl/game_state_regfile_if.sv
// Update-side and display-side signal bundle for the double-buffered game-state register file.
// The master drives the shadow controls and data; the slave returns the committed frame state.
interface game_state_regfile_if #(
    parameter int NUM_PLATS = 4,
    parameter int POS_W     = 8,
    parameter int COLOR_W   = 3,
    parameter int SCORE_W   = 16
);
    logic                         restart;
    logic                         wr_en;
    logic [POS_W-1:0]             curr_ball_in;
    logic [COLOR_W-1:0]           color_ball_in;
    logic [NUM_PLATS*COLOR_W-1:0] color_plats_in;
    logic [NUM_PLATS*POS_W-1:0]   position_plats_in;
    logic [SCORE_W-1:0]           score_in;
    logic                         shift_en;
    logic [POS_W-1:0]             new_plat_pos;
    logic [COLOR_W-1:0]           new_plat_color;
    logic                         frame_tick;

    logic [POS_W-1:0]             prev_ball_out;
    logic [POS_W-1:0]             curr_ball_out;
    logic [COLOR_W-1:0]           color_ball_out;
    logic [NUM_PLATS*COLOR_W-1:0] color_plats_out;
    logic [NUM_PLATS*POS_W-1:0]   position_plats_out;
    logic [SCORE_W-1:0]           score_out;
    logic [SCORE_W-1:0]           high_score_out;
    logic                         pending;
    logic                         commit_pulse;

    modport master (
        output restart, wr_en, curr_ball_in, color_ball_in, color_plats_in,
               position_plats_in, score_in, shift_en, new_plat_pos,
               new_plat_color, frame_tick,
        input  prev_ball_out, curr_ball_out, color_ball_out, color_plats_out,
               position_plats_out, score_out, high_score_out, pending, commit_pulse
    );

    modport slave (
        input  restart, wr_en, curr_ball_in, color_ball_in, color_plats_in,
               position_plats_in, score_in, shift_en, new_plat_pos,
               new_plat_color, frame_tick,
        output prev_ball_out, curr_ball_out, color_ball_out, color_plats_out,
               position_plats_out, score_out, high_score_out, pending, commit_pulse
    );
endinterface

// File: rtl/game_state_regfile.sv
// Double-buffered game-state register file: updates land in a shadow copy that is
// committed to the display-facing outputs only on a frame tick while a change is pending.
module game_state_regfile #(
    parameter int                               NUM_PLATS       = 4,
    parameter int                               POS_W           = 8,
    parameter int                               COLOR_W         = 3,
    parameter int                               SCORE_W         = 16,
    parameter logic [COLOR_W-1:0]               RST_BALL_COLOR  = 3'b111,
    parameter logic [NUM_PLATS*COLOR_W-1:0]     RST_PLAT_COLORS = 12'b001110111101,
    parameter logic [NUM_PLATS*POS_W-1:0]       RST_PLAT_POS    = 32'b01011111011100111000011110011011
) (
    input  logic                clk,
    input  logic                reset,
    game_state_regfile_if.slave bus
);
    localparam int PLAT_CW = NUM_PLATS * COLOR_W;
    localparam int PLAT_PW = NUM_PLATS * POS_W;

    logic [POS_W-1:0]   sh_ball_r;
    logic [COLOR_W-1:0] sh_ball_color_r;
    logic [PLAT_CW-1:0] sh_plat_color_r;
    logic [PLAT_PW-1:0] sh_plat_pos_r;
    logic [SCORE_W-1:0] sh_score_r;

    logic [POS_W-1:0]   sh_ball_s;
    logic [COLOR_W-1:0] sh_ball_color_s;
    logic [PLAT_CW-1:0] sh_plat_color_s;
    logic [PLAT_PW-1:0] sh_plat_pos_s;
    logic [SCORE_W-1:0] sh_score_s;
    logic               shadow_mod_s;

    logic [PLAT_CW-1:0] shifted_color_s;
    logic [PLAT_PW-1:0] shifted_pos_s;
    logic               commit_s;

    logic [POS_W-1:0]   curr_ball_r;
    logic [POS_W-1:0]   prev_ball_r;
    logic [COLOR_W-1:0] color_ball_r;
    logic [PLAT_CW-1:0] color_plats_r;
    logic [PLAT_PW-1:0] position_plats_r;
    logic [SCORE_W-1:0] score_r;
    logic [SCORE_W-1:0] high_score_r;
    logic               pending_r;
    logic               commit_pulse_r;

    // Scroll the shadow platforms down one slot, feeding the new platform into the top slot.
    always_comb begin
        shifted_color_s = sh_plat_color_r;
        shifted_pos_s   = sh_plat_pos_r;
        for (int i = 0; i < NUM_PLATS - 1; i++) begin
            shifted_color_s[i*COLOR_W +: COLOR_W] = sh_plat_color_r[(i+1)*COLOR_W +: COLOR_W];
            shifted_pos_s[i*POS_W +: POS_W]       = sh_plat_pos_r[(i+1)*POS_W +: POS_W];
        end
        shifted_color_s[(NUM_PLATS-1)*COLOR_W +: COLOR_W] = bus.new_plat_color;
        shifted_pos_s[(NUM_PLATS-1)*POS_W +: POS_W]       = bus.new_plat_pos;
    end

    // Next shadow contents: restart beats write/shift; shift beats write for the platform arrays.
    always_comb begin
        sh_ball_s       = sh_ball_r;
        sh_ball_color_s = sh_ball_color_r;
        sh_plat_color_s = sh_plat_color_r;
        sh_plat_pos_s   = sh_plat_pos_r;
        sh_score_s      = sh_score_r;
        shadow_mod_s    = 1'b0;
        if (bus.restart) begin
            sh_ball_s       = {POS_W{1'b0}};
            sh_ball_color_s = RST_BALL_COLOR;
            sh_plat_color_s = RST_PLAT_COLORS;
            sh_plat_pos_s   = RST_PLAT_POS;
            sh_score_s      = {SCORE_W{1'b0}};
            shadow_mod_s    = 1'b1;
        end else if (bus.wr_en || bus.shift_en) begin
            shadow_mod_s = 1'b1;
            if (bus.wr_en) begin
                sh_ball_s       = bus.curr_ball_in;
                sh_ball_color_s = bus.color_ball_in;
                sh_score_s      = bus.score_in;
            end else begin
                sh_ball_s       = sh_ball_r;
                sh_ball_color_s = sh_ball_color_r;
                sh_score_s      = sh_score_r;
            end
            if (bus.shift_en) begin
                sh_plat_color_s = shifted_color_s;
                sh_plat_pos_s   = shifted_pos_s;
            end else begin
                sh_plat_color_s = bus.color_plats_in;
                sh_plat_pos_s   = bus.position_plats_in;
            end
        end else begin
            shadow_mod_s = 1'b0;
        end
    end

    assign commit_s = bus.frame_tick && pending_r;

    // Shadow storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_ball_r       <= {POS_W{1'b0}};
            sh_ball_color_r <= RST_BALL_COLOR;
            sh_plat_color_r <= RST_PLAT_COLORS;
            sh_plat_pos_r   <= RST_PLAT_POS;
            sh_score_r      <= {SCORE_W{1'b0}};
        end else begin
            sh_ball_r       <= sh_ball_s;
            sh_ball_color_r <= sh_ball_color_s;
            sh_plat_color_r <= sh_plat_color_s;
            sh_plat_pos_r   <= sh_plat_pos_s;
            sh_score_r      <= sh_score_s;
        end
    end

    // Committed frame state: copies the pre-update shadow on a tick while a change is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curr_ball_r      <= {POS_W{1'b0}};
            prev_ball_r      <= {POS_W{1'b0}};
            color_ball_r     <= RST_BALL_COLOR;
            color_plats_r    <= RST_PLAT_COLORS;
            position_plats_r <= RST_PLAT_POS;
            score_r          <= {SCORE_W{1'b0}};
            high_score_r     <= {SCORE_W{1'b0}};
            commit_pulse_r   <= 1'b0;
        end else if (commit_s) begin
            curr_ball_r      <= sh_ball_r;
            prev_ball_r      <= curr_ball_r;
            color_ball_r     <= sh_ball_color_r;
            color_plats_r    <= sh_plat_color_r;
            position_plats_r <= sh_plat_pos_r;
            score_r          <= sh_score_r;
            high_score_r     <= (sh_score_r > high_score_r) ? sh_score_r : high_score_r;
            commit_pulse_r   <= 1'b1;
        end else begin
            commit_pulse_r   <= 1'b0;
        end
    end

    // A change arriving on the commit edge keeps pending set so it goes out on the next tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (shadow_mod_s) begin
            pending_r <= 1'b1;
        end else if (commit_s) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    assign bus.curr_ball_out      = curr_ball_r;
    assign bus.prev_ball_out      = prev_ball_r;
    assign bus.color_ball_out     = color_ball_r;
    assign bus.color_plats_out    = color_plats_r;
    assign bus.position_plats_out = position_plats_r;
    assign bus.score_out          = score_r;
    assign bus.high_score_out     = high_score_r;
    assign bus.pending            = pending_r;
    assign bus.commit_pulse       = commit_pulse_r;
endmodule

// File: tb/tb_game_state_regfile.sv
// Self-checking bench for game_state_regfile: directed vector table, hand-written corner
// sequences and randomized traffic compared against a slot-array reference model.
module tb_game_state_regfile;
    localparam int NP = 4;
    localparam logic [2:0]  D_BCOL = 3'b111;
    localparam logic [11:0] D_PCOL = 12'b001110111101;
    localparam logic [31:0] D_PPOS = 32'h5F73879B;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    game_state_regfile_if bus ();

    game_state_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: shadow and committed state held as per-slot arrays.
    logic [7:0]  s_ball, c_ball, c_prev;
    logic [2:0]  s_bcol, c_bcol;
    logic [15:0] s_score, c_score, m_hi;
    logic [7:0]  s_pos[NP], c_pos[NP];
    logic [2:0]  s_col[NP], c_col[NP];
    logic        m_pend, m_pulse;

    function automatic logic [31:0] pack_pos(input logic [7:0] p[NP]);
        logic [31:0] v;
        for (int i = 0; i < NP; i++) v[i*8 +: 8] = p[i];
        return v;
    endfunction

    function automatic logic [11:0] pack_col(input logic [2:0] c[NP]);
        logic [11:0] v;
        for (int i = 0; i < NP; i++) v[i*3 +: 3] = c[i];
        return v;
    endfunction

    task automatic load_defaults_shadow();
        logic [31:0] p;
        logic [11:0] c;
        p = D_PPOS;
        c = D_PCOL;
        s_ball = 8'd0; s_bcol = D_BCOL; s_score = 16'd0;
        for (int i = 0; i < NP; i++) begin
            s_pos[i] = p[i*8 +: 8];
            s_col[i] = c[i*3 +: 3];
        end
    endtask

    task automatic model_reset();
        load_defaults_shadow();
        c_ball = 8'd0; c_prev = 8'd0; c_bcol = D_BCOL; c_score = 16'd0;
        for (int i = 0; i < NP; i++) begin
            c_pos[i] = s_pos[i];
            c_col[i] = s_col[i];
        end
        m_hi = 16'd0; m_pend = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_edge();
        logic commit;
        logic modified;
        commit = bus.frame_tick && m_pend;
        if (commit) begin
            c_prev = c_ball; c_ball = s_ball; c_bcol = s_bcol; c_score = s_score;
            for (int i = 0; i < NP; i++) begin
                c_pos[i] = s_pos[i];
                c_col[i] = s_col[i];
            end
            if (s_score > m_hi) m_hi = s_score;
            m_pulse = 1'b1;
        end else begin
            m_pulse = 1'b0;
        end
        modified = bus.restart || bus.wr_en || bus.shift_en;
        if (bus.restart) begin
            load_defaults_shadow();
        end else begin
            if (bus.wr_en) begin
                s_ball = bus.curr_ball_in; s_bcol = bus.color_ball_in; s_score = bus.score_in;
            end
            if (bus.shift_en) begin
                for (int i = 0; i < NP - 1; i++) begin
                    s_pos[i] = s_pos[i+1];
                    s_col[i] = s_col[i+1];
                end
                s_pos[NP-1] = bus.new_plat_pos;
                s_col[NP-1] = bus.new_plat_color;
            end else if (bus.wr_en) begin
                for (int i = 0; i < NP; i++) begin
                    s_pos[i] = bus.position_plats_in[i*8 +: 8];
                    s_col[i] = bus.color_plats_in[i*3 +: 3];
                end
            end
        end
        if (modified) m_pend = 1'b1;
        else if (commit) m_pend = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".curr_ball"}, 64'(bus.curr_ball_out), 64'(c_ball));
        chk({tag, ".prev_ball"}, 64'(bus.prev_ball_out), 64'(c_prev));
        chk({tag, ".color_ball"}, 64'(bus.color_ball_out), 64'(c_bcol));
        chk({tag, ".color_plats"}, 64'(bus.color_plats_out), 64'(pack_col(c_col)));
        chk({tag, ".position_plats"}, 64'(bus.position_plats_out), 64'(pack_pos(c_pos)));
        chk({tag, ".score"}, 64'(bus.score_out), 64'(c_score));
        chk({tag, ".high_score"}, 64'(bus.high_score_out), 64'(m_hi));
        chk({tag, ".pending"}, 64'(bus.pending), 64'(m_pend));
        chk({tag, ".commit_pulse"}, 64'(bus.commit_pulse), 64'(m_pulse));
    endtask

    task automatic idle();
        bus.restart = 1'b0; bus.wr_en = 1'b0; bus.shift_en = 1'b0; bus.frame_tick = 1'b0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges; defaults must appear with no edge.
    task automatic do_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".def_pos"}, 64'(bus.position_plats_out), 64'(D_PPOS));
        chk({tag, ".def_col"}, 64'(bus.color_plats_out), 64'(D_PCOL));
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic        rs, wr, sh, tk;
        logic [7:0]  ball;
        logic [15:0] score;
        logic [7:0]  e_ball, e_prev;
        logic [15:0] e_score, e_hi;
        logic [31:0] e_pos;
        logic        e_pend, e_pulse;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic rs, wr, tk, input logic [7:0] ball, input logic [15:0] score,
                                input logic [7:0] e_ball, e_prev, input logic [15:0] e_score, e_hi,
                                input logic [31:0] e_pos, input logic e_pend, e_pulse);
        vec_t v;
        v.rs = rs; v.wr = wr; v.sh = 1'b0; v.tk = tk; v.ball = ball; v.score = score;
        v.e_ball = e_ball; v.e_prev = e_prev; v.e_score = e_score; v.e_hi = e_hi;
        v.e_pos = e_pos; v.e_pend = e_pend; v.e_pulse = e_pulse;
        return v;
    endfunction

    localparam logic [31:0] W_POS = 32'h11223344;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        idle();
        bus.curr_ball_in = 8'd0; bus.color_ball_in = 3'd0; bus.score_in = 16'd0;
        bus.color_plats_in = 12'h5A5; bus.position_plats_in = W_POS;
        bus.new_plat_pos = 8'd0; bus.new_plat_color = 3'd0;

        //             rs   wr   tk   ball    score   e_ball  e_prev  e_score e_hi    e_pos   pend pulse
        tbl[0]  = mk(1'b0,1'b1,1'b0, 8'd40, 16'd5,   8'd0,   8'd0,   16'd0,  16'd0,  D_PPOS, 1'b1,1'b0);
        tbl[1]  = mk(1'b0,1'b0,1'b1, 8'd0,  16'd0,   8'd40,  8'd0,   16'd5,  16'd5,  W_POS,  1'b0,1'b1);
        tbl[2]  = mk(1'b0,1'b0,1'b0, 8'd0,  16'd0,   8'd40,  8'd0,   16'd5,  16'd5,  W_POS,  1'b0,1'b0);
        tbl[3]  = mk(1'b0,1'b1,1'b0, 8'd40, 16'd5,   8'd40,  8'd0,   16'd5,  16'd5,  W_POS,  1'b1,1'b0);
        tbl[4]  = mk(1'b0,1'b1,1'b1, 8'd60, 16'd7,   8'd40,  8'd40,  16'd5,  16'd5,  W_POS,  1'b1,1'b1);
        tbl[5]  = mk(1'b0,1'b0,1'b1, 8'd0,  16'd0,   8'd60,  8'd40,  16'd7,  16'd7,  W_POS,  1'b0,1'b1);
        tbl[6]  = mk(1'b0,1'b0,1'b1, 8'd0,  16'd0,   8'd60,  8'd40,  16'd7,  16'd7,  W_POS,  1'b0,1'b0);
        tbl[7]  = mk(1'b0,1'b1,1'b0, 8'd100,16'd100, 8'd60,  8'd40,  16'd7,  16'd7,  W_POS,  1'b1,1'b0);
        tbl[8]  = mk(1'b0,1'b0,1'b1, 8'd0,  16'd0,   8'd100, 8'd60,  16'd100,16'd100,W_POS,  1'b0,1'b1);
        tbl[9]  = mk(1'b1,1'b1,1'b0, 8'd3,  16'd3,   8'd100, 8'd60,  16'd100,16'd100,W_POS,  1'b1,1'b0);
        tbl[10] = mk(1'b0,1'b0,1'b1, 8'd0,  16'd0,   8'd0,   8'd100, 16'd0,  16'd100,D_PPOS, 1'b0,1'b1);
        tbl[11] = mk(1'b0,1'b1,1'b0, 8'd9,  16'd50,  8'd0,   8'd100, 16'd0,  16'd100,D_PPOS, 1'b1,1'b0);
        tbl[12] = mk(1'b0,1'b0,1'b1, 8'd0,  16'd0,   8'd9,   8'd0,   16'd50, 16'd100,W_POS,  1'b0,1'b1);

        // Reset with no clock edge seen yet.
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("por");
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 13; k++) begin
            bus.restart = tbl[k].rs; bus.wr_en = tbl[k].wr; bus.shift_en = tbl[k].sh;
            bus.frame_tick = tbl[k].tk; bus.curr_ball_in = tbl[k].ball; bus.score_in = tbl[k].score;
            step();
            chk($sformatf("tbl%0d.curr_ball", k), 64'(bus.curr_ball_out), 64'(tbl[k].e_ball));
            chk($sformatf("tbl%0d.prev_ball", k), 64'(bus.prev_ball_out), 64'(tbl[k].e_prev));
            chk($sformatf("tbl%0d.score", k), 64'(bus.score_out), 64'(tbl[k].e_score));
            chk($sformatf("tbl%0d.high_score", k), 64'(bus.high_score_out), 64'(tbl[k].e_hi));
            chk($sformatf("tbl%0d.position_plats", k), 64'(bus.position_plats_out), 64'(tbl[k].e_pos));
            chk($sformatf("tbl%0d.pending", k), 64'(bus.pending), 64'(tbl[k].e_pend));
            chk($sformatf("tbl%0d.commit_pulse", k), 64'(bus.commit_pulse), 64'(tbl[k].e_pulse));
        end
        idle();

        // Shift alone, then shift together with a write.
        do_reset("rst_shift");
        bus.shift_en = 1'b1; bus.new_plat_pos = 8'hAA; bus.new_plat_color = 3'b010;
        step();
        idle(); bus.frame_tick = 1'b1;
        step();
        chk("shift.pos", 64'(bus.position_plats_out), 64'h00000000AA5F7387);
        chk("shift.col", 64'(bus.color_plats_out), 64'(12'b010001110111));
        idle();
        bus.wr_en = 1'b1; bus.shift_en = 1'b1; bus.curr_ball_in = 8'd33; bus.score_in = 16'd12;
        bus.position_plats_in = 32'hDEADBEEF; bus.color_plats_in = 12'hFFF;
        bus.new_plat_pos = 8'h11; bus.new_plat_color = 3'b001;
        step();
        idle(); bus.frame_tick = 1'b1;
        step();
        chk("wrshift.pos", 64'(bus.position_plats_out), 64'h0000000011AA5F73);
        chk("wrshift.col", 64'(bus.color_plats_out), 64'(12'b001010001110));
        chk("wrshift.ball", 64'(bus.curr_ball_out), 64'd33);
        chk("wrshift.score", 64'(bus.score_out), 64'd12);
        chk("wrshift.hi", 64'(bus.high_score_out), 64'd12);
        idle();

        // Reset between a write and its tick discards the write.
        bus.wr_en = 1'b1; bus.curr_ball_in = 8'd77; bus.score_in = 16'd999;
        step();
        idle();
        do_reset("rst_mid");
        bus.frame_tick = 1'b1;
        step();
        chk("discard.ball", 64'(bus.curr_ball_out), 64'd0);
        chk("discard.score", 64'(bus.score_out), 64'd0);
        chk("discard.pending", 64'(bus.pending), 64'd0);
        chk("discard.pulse", 64'(bus.commit_pulse), 64'd0);
        check_all("discard");
        idle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bus.restart    = ($urandom_range(0, 31) == 0);
            bus.wr_en      = ($urandom_range(0, 2) == 0);
            bus.shift_en   = ($urandom_range(0, 3) == 0);
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            bus.curr_ball_in      = 8'($urandom);
            bus.color_ball_in     = 3'($urandom);
            bus.color_plats_in    = 12'($urandom);
            bus.position_plats_in = 32'($urandom);
            bus.score_in          = 16'($urandom);
            bus.new_plat_pos      = 8'($urandom);
            bus.new_plat_color    = 3'($urandom);
            step();
            check_all($sformatf("rnd%0d", n));
            if ($urandom_range(0, 499) == 0) begin
                idle();
                do_reset($sformatf("rndrst%0d", n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_state_regfile.md
Name: game_state_regfile

Overview:
- Parametrised, double-buffered game-state register file for the colour-bounce game.
- The update logic writes a shadow copy at any time. The shadow is committed to the display-facing outputs only on a frame tick, so the VGA drawer never sees a half-updated frame.
- Additions over the fixed single-buffer memory:
  - N platform slots with a scroll/shift mode.
  - A soft restart that keeps the high score.
  - High-score tracking.
  - A commit handshake.

Parameters:
- NUM_PLATS, 4, number of platform slots.
- POS_W, 8, width of one position (ball or platform).
- COLOR_W, 3, width of one colour code.
- SCORE_W, 16, score width.
- RST_BALL_COLOR, 3'b111, ball colour loaded on reset or restart.
- RST_PLAT_COLORS, 12'b001110111101, NUM_PLATS*COLOR_W packed default colours; slot 0 is in the LSBs.
- RST_PLAT_POS, 32'b01011111011100111000011110011011, NUM_PLATS*POS_W packed default positions; slot 0 is in the LSBs.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears everything including the high score
- restart  in  1  synchronous soft restart; reloads the shadow with defaults and keeps the high score
- wr_en  in  1  write the shadow from the *_in fields this cycle
- curr_ball_in  in  POS_W  new ball position
- color_ball_in  in  COLOR_W  new ball colour
- color_plats_in  in  NUM_PLATS*COLOR_W  new platform colours
- position_plats_in  in  NUM_PLATS*POS_W  new platform positions
- score_in  in  SCORE_W  new score
- shift_en  in  1  scroll the platform slots by one
- new_plat_pos  in  POS_W  position entering the top slot on a shift
- new_plat_color  in  COLOR_W  colour entering the top slot on a shift
- frame_tick  in  1  single-cycle frame boundary strobe
- prev_ball_out  out  POS_W  committed ball position of the previous frame
- curr_ball_out  out  POS_W  committed ball position
- color_ball_out  out  COLOR_W  committed ball colour
- color_plats_out  out  NUM_PLATS*COLOR_W  committed platform colours
- position_plats_out  out  NUM_PLATS*POS_W  committed platform positions
- score_out  out  SCORE_W  committed score
- high_score_out  out  SCORE_W  best committed score since reset
- pending  out  1  shadow differs from committed (a write, shift or restart is awaiting commit)
- commit_pulse  out  1  high for exactly one cycle, the cycle after a commit

Behaviour:

Reset (asynchronous, takes effect immediately):
- Shadow and committed registers load: curr_ball=0, color_ball=RST_BALL_COLOR, color_plats=RST_PLAT_COLORS, position_plats=RST_PLAT_POS, score=0.
- prev_ball_out=0, high_score_out=0, pending=0, commit_pulse=0.
- Reset asserted mid-frame discards any pending shadow.

Shadow update, per clock edge, in priority order:
1. restart=1: shadow loads the same values as reset (curr_ball=0, color_ball=RST_BALL_COLOR, color_plats=RST_PLAT_COLORS, position_plats=RST_PLAT_POS, score=0). wr_en and shift_en are ignored. pending<=1.
2. wr_en=1 and/or shift_en=1:
   - wr_en writes curr_ball, color_ball and score from the *_in fields.
   - wr_en alone also writes the platform arrays from color_plats_in and position_plats_in.
   - shift_en shifts the current shadow platform arrays: slot i <= slot i+1 for i < NUM_PLATS-1; the top slot <= new_plat_pos / new_plat_color.
   - When wr_en and shift_en are both high, the shift wins for the platform arrays; wr_en still applies to the ball and score fields.
   - pending<=1.
3. Otherwise the shadow holds.

Commit (frame_tick=1 and pending=1):
- All committed fields <= shadow, using the shadow value from before this edge's update.
- prev_ball_out <= the old curr_ball_out.
- If shadow score > high_score_out (unsigned), high_score_out <= shadow score.
- commit_pulse <= 1 on this edge, then 0 on the next edge.
- pending <= 0, unless a restart, write or shift occurs on the same edge; then pending stays 1 and that new data commits on the next tick.

Other timing rules:
- frame_tick with pending=0: no effect; prev_ball_out holds and commit_pulse stays 0.
- Latency: data written on edge N is visible on the outputs at the first commit edge strictly after N.
- Score and high score are plain registers; there is no arithmetic on score and no wrap.
- restart never alters high_score_out.

Test Plan:
- Assert reset mid-cycle with no clock edge -> outputs immediately show defaults: color_plats_out=12'b001110111101, position_plats_out=32'h5F73879B, color_ball_out=3'b111, curr_ball_out=0, score_out=0, high_score_out=0, pending=0, commit_pulse=0.
- wr_en with curr_ball_in=8'd40 and score_in=16'd5, no tick -> outputs unchanged and pending=1. Next frame_tick -> curr_ball_out=40, prev_ball_out=0, score_out=5, high_score_out=5, commit_pulse high for one cycle, pending=0.
- wr_en and frame_tick on the same edge, with the shadow holding curr_ball=40 and the write carrying 60 -> commit shows 40 and pending stays 1. Next tick -> curr_ball_out=60, prev_ball_out=40.
- shift_en with new_plat_pos=8'hAA and new_plat_color=3'b010, then tick -> position_plats_out=32'hAA5F7387, color_plats_out=12'b010001110111. With wr_en also high on the shift edge, the platforms still show the shifted values while the ball and score show the wr_en values.
- After score 100 is committed, pulse restart, then tick -> score_out=0, curr_ball_out=0, platforms at defaults, high_score_out=100. A later commit of score 50 leaves high_score_out=100.
- frame_tick with pending=0 -> no output change, commit_pulse=0. Assert reset between a write and its tick -> the written data never appears at the outputs.
